// File: rtl/reg_bank_arbiter.sv
// reg_bank_arbiter: two-requester round-robin arbiter in front of a bank of
// NrOfRegs registers that share one write-data bus and one tri-state read bus.
//
// Ports:
//   clk, rst          system clock, asynchronous active-high reset
//   tick              global advance enable; nothing changes on edges with tick=0
//   req0/req1         access requests, held until the matching done pulse
//   we0/we1           1=write, 0=read
//   addr0/addr1       target register index
//   wdata0/wdata1     write data
//   clr_req           request to clear the whole bank
//   bus_in            resolved tri-state bus from the bank
//   reg_we            one-hot register clock-enable
//   reg_cs            per-register output disable (1=high-Z, 0=drive bus)
//   reg_d             shared write data to every register
//   reg_clr           bank clear pulse
//   done0/done1       one-cycle completion pulse per requester
//   rdata             registered read result
//   err               valid with done; 1=address out of range
//   busy              FSM not idle
module reg_bank_arbiter #(
    parameter int unsigned NrOfRegs = 8,
    parameter int unsigned AddrBits = 3,
    parameter int unsigned NrOfBits = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick,
    input  logic                req0,
    input  logic                req1,
    input  logic                we0,
    input  logic                we1,
    input  logic [AddrBits-1:0] addr0,
    input  logic [AddrBits-1:0] addr1,
    input  logic [NrOfBits-1:0] wdata0,
    input  logic [NrOfBits-1:0] wdata1,
    input  logic                clr_req,
    input  logic [NrOfBits-1:0] bus_in,
    output logic [NrOfRegs-1:0] reg_we,
    output logic [NrOfRegs-1:0] reg_cs,
    output logic [NrOfBits-1:0] reg_d,
    output logic                reg_clr,
    output logic                done0,
    output logic                done1,
    output logic [NrOfBits-1:0] rdata,
    output logic                err,
    output logic                busy
);

    typedef enum logic [1:0] {StIdle, StAccess, StClear, StDone} state_e;

    localparam logic [NrOfRegs-1:0] OneHotLsb = NrOfRegs'(1);

    state_e              state;
    logic                last_served;  // requester granted most recently
    logic                we_q;
    logic [AddrBits-1:0] addr_q;
    logic                owner_q;

    logic                winner;
    logic                sel_we;
    logic [AddrBits-1:0] sel_addr;
    logic [NrOfBits-1:0] sel_wdata;
    logic                sel_ok;
    logic                access_ok;

    // With both requesting, the one not served last wins; last_served resets
    // to 1 so requester 0 is favoured first.
    always_comb begin
        winner    = (req0 && req1) ? ~last_served : req1;
        sel_we    = winner ? we1 : we0;
        sel_addr  = winner ? addr1 : addr0;
        sel_wdata = winner ? wdata1 : wdata0;
        sel_ok    = 32'(sel_addr) < NrOfRegs;
        access_ok = 32'(addr_q) < NrOfRegs;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= StIdle;
            last_served <= 1'b1;
            we_q        <= 1'b0;
            addr_q      <= '0;
            owner_q     <= 1'b0;
            reg_we      <= '0;
            reg_cs      <= '1;
            reg_d       <= '0;
            reg_clr     <= 1'b0;
            done0       <= 1'b0;
            done1       <= 1'b0;
            rdata       <= '0;
            err         <= 1'b0;
            busy        <= 1'b0;
        end else if (tick) begin
            case (state)
                StIdle: begin
                    if (clr_req) begin
                        state   <= StClear;
                        reg_clr <= 1'b1;
                        busy    <= 1'b1;
                    end else if (req0 || req1) begin
                        state       <= StAccess;
                        busy        <= 1'b1;
                        we_q        <= sel_we;
                        addr_q      <= sel_addr;
                        owner_q     <= winner;
                        last_served <= winner;
                        if (sel_we) begin
                            reg_d <= sel_wdata;
                        end
                        // Out-of-range accesses leave the bank untouched.
                        if (sel_ok) begin
                            if (sel_we) begin
                                reg_we <= OneHotLsb << sel_addr;
                            end else begin
                                reg_cs <= ~(OneHotLsb << sel_addr);
                            end
                        end
                    end
                end
                StAccess: begin
                    state  <= StDone;
                    reg_we <= '0;
                    reg_cs <= '1;
                    done0  <= ~owner_q;
                    done1  <= owner_q;
                    if (!access_ok) begin
                        rdata <= '0;
                        err   <= 1'b1;
                    end else if (!we_q) begin
                        rdata <= bus_in;
                    end
                end
                StClear: begin
                    state   <= StIdle;
                    reg_clr <= 1'b0;
                    busy    <= 1'b0;
                end
                StDone: begin
                    state <= StIdle;
                    done0 <= 1'b0;
                    done1 <= 1'b0;
                    err   <= 1'b0;
                    busy  <= 1'b0;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
